// File: rtl/eth_pkg.sv
// Shared types for the Ethernet transmit path: AXI-stream beat layout and
// the arbiter FSM encoding.
package eth_pkg;

   localparam int AXIS_DATA_W = 64;
   localparam int AXIS_KEEP_W = 8;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_t;

   typedef struct packed {
      logic [AXIS_DATA_W-1:0] data;
      logic [AXIS_KEEP_W-1:0] keep;
      logic                   last;
   } axis_beat_t;

   // Every byte lane enabled: the only legal KEEP on a non-final beat.
   function automatic logic keep_full(input logic [AXIS_KEEP_W-1:0] keep);
      return &keep;
   endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry AXI-stream register slice: fully registered output (main entry)
// plus one skid entry that catches the beat in flight when out_ready drops.
module axis_skid_slice
   import eth_pkg::*;
(
   input  logic       clk,
   input  logic       aresetn,
   input  logic       in_valid,
   input  axis_beat_t in_beat,
   output logic       in_ready,
   output logic       out_valid,
   output axis_beat_t out_beat,
   input  logic       out_ready
);

   // Handshake on both sides: a beat moves when valid && ready are both high
   // at a rising edge; valid must hold with stable payload until it moves.
   logic       main_valid, main_valid_n;
   logic       skid_valid, skid_valid_n;
   axis_beat_t main_q, main_n;
   axis_beat_t skid_q, skid_n;
   logic       accept;
   logic       pop;

   always_comb begin
      accept       = in_valid && in_ready;
      pop          = main_valid && out_ready;
      main_valid_n = main_valid;
      skid_valid_n = skid_valid;
      main_n       = main_q;
      skid_n       = skid_q;
      if (skid_valid) begin
         // in_ready is low here, so only the drain side can move.
         if (pop) begin
            main_n       = skid_q;
            skid_valid_n = 1'b0;
         end
      end else if (!main_valid || pop) begin
         main_valid_n = accept;
         if (accept) begin
            main_n = in_beat;
         end
      end else if (accept) begin
         skid_n       = in_beat;
         skid_valid_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready   <= 1'b1;
      end else begin
         main_valid <= main_valid_n;
         skid_valid <= skid_valid_n;
         main_q     <= main_n;
         skid_q     <= skid_n;
         in_ready   <= !skid_valid_n;
      end
   end

   assign out_valid = main_valid;
   assign out_beat  = main_q;

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one 64-bit AXI-stream transmit
// path between N_SRC sources, with per-source packet counters.
module eth_tx_arbiter
   import eth_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         aresetn,
   input  logic [N_SRC*AXIS_DATA_W-1:0] src_DATA,
   input  logic [N_SRC*AXIS_KEEP_W-1:0] src_KEEP,
   input  logic [N_SRC-1:0]             src_LAST,
   input  logic [N_SRC-1:0]             src_VALID,
   output logic [N_SRC-1:0]             src_READY,
   output logic [AXIS_DATA_W-1:0]       stream_out_DATA,
   output logic [AXIS_KEEP_W-1:0]       stream_out_KEEP,
   output logic                         stream_out_LAST,
   output logic                         stream_out_VALID,
   input  logic                         stream_out_READY,
   output logic [N_SRC-1:0]             grant,
   output logic [N_SRC*CNT_W-1:0]       pkt_cnt,
   output logic                         err_keep,
   output logic                         arb_state
);

   localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   arb_state_t       state_q, state_n;
   logic [N_SRC-1:0] grant_q;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] sel_idx;
   logic [CNT_W-1:0] cnt_q [N_SRC];
   logic             err_keep_q;

   logic             start_grant;
   logic             pkt_done;
   logic             cur_valid;
   logic             cur_last;
   logic [AXIS_KEEP_W-1:0] cur_keep;
   logic [AXIS_DATA_W-1:0] cur_data;

   logic             slice_in_valid;
   logic             slice_in_ready;
   logic             src_accept;
   axis_beat_t       slice_in_beat;
   axis_beat_t       slice_out_beat;
   logic             slice_out_valid;

   // First requester strictly after 'last', searching cyclically.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                                input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= N_SRC; k++) begin
         idx = (int'(last) + k) % N_SRC;
         if (!found && req[idx]) begin
            pick  = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // last_grant doubles as the owner index while BUSY.
   always_comb begin
      cur_valid = src_VALID[last_grant];
      cur_last  = src_LAST[last_grant];
      cur_keep  = src_KEEP[int'(last_grant)*AXIS_KEEP_W +: AXIS_KEEP_W];
      cur_data  = src_DATA[int'(last_grant)*AXIS_DATA_W +: AXIS_DATA_W];
   end

   always_comb begin
      state_n        = state_q;
      src_READY      = '0;
      slice_in_valid = 1'b0;
      start_grant    = 1'b0;
      pkt_done       = 1'b0;
      sel_idx        = rr_pick(src_VALID, last_grant);
      case (state_q)
         ARB_IDLE: begin
            if (|src_VALID) begin
               start_grant = 1'b1;
               state_n     = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            src_READY[last_grant] = slice_in_ready;
            slice_in_valid        = cur_valid;
            if (cur_valid && slice_in_ready && cur_last) begin
               pkt_done = 1'b1;
               state_n  = ARB_IDLE;
            end
         end
         default: state_n = ARB_IDLE;
      endcase
      src_accept = slice_in_valid && slice_in_ready;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         grant_q    <= '0;
         last_grant <= IDX_W'(N_SRC - 1);
         err_keep_q <= 1'b0;
         for (int i = 0; i < N_SRC; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         if (start_grant) begin
            grant_q    <= {{(N_SRC-1){1'b0}}, 1'b1} << sel_idx;
            last_grant <= sel_idx;
         end
         if (pkt_done) begin
            grant_q           <= '0;
            cnt_q[last_grant] <= cnt_q[last_grant] + CNT_W'(1);
         end
         // Flag only; the offending beat is forwarded untouched.
         if (src_accept && !cur_last && !keep_full(cur_keep)) begin
            err_keep_q <= 1'b1;
         end
      end
   end

   assign slice_in_beat = '{data: cur_data, keep: cur_keep, last: cur_last};

   axis_skid_slice u_slice (
      .clk       (clk),
      .aresetn   (aresetn),
      .in_valid  (slice_in_valid),
      .in_beat   (slice_in_beat),
      .in_ready  (slice_in_ready),
      .out_valid (slice_out_valid),
      .out_beat  (slice_out_beat),
      .out_ready (stream_out_READY)
   );

   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cnt
      assign pkt_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
   end

   assign stream_out_VALID = slice_out_valid;
   assign stream_out_DATA  = slice_out_beat.data;
   assign stream_out_KEEP  = slice_out_beat.keep;
   assign stream_out_LAST  = slice_out_beat.last;
   assign grant            = grant_q;
   assign err_keep         = err_keep_q;
   assign arb_state        = (state_q == ARB_BUSY);

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Round-robin packet arbiter that shares the single 64-bit AXI-stream transmit path into the Ethernet core between `N_SRC` packet sources, including stimulus generators and the JSON-driven packet player. Grants are packet-atomic: once a source wins, it owns `stream_out` until its `LAST` beat is accepted. Output is fully registered through a two-entry skid slice, so a packet in progress runs at one beat per cycle. Per-source packet counters and a sticky KEEP-violation flag are exported for bench and debug visibility.

## Interface
- `N_SRC`, default 4, number of sources; legal range 2..8.
- `CNT_W`, default 16, width of each per-source packet counter.
- `clk` in 1: single clock; all logic is rising-edge.
- `aresetn` in 1: asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to `clk`.
- `src_DATA` in `N_SRC*64`: source i data is bits [64i+63:64i].
- `src_KEEP` in `N_SRC*8`: byte enables per source.
- `src_LAST` in `N_SRC`: end-of-packet per source.
- `src_VALID` in `N_SRC`: beat valid per source.
- `src_READY` out `N_SRC`: beat accepted per source.
- `stream_out_DATA` out 64, `stream_out_KEEP` out 8, `stream_out_LAST` out 1, `stream_out_VALID` out 1: registered AXI-stream toward the Ethernet core.
- `stream_out_READY` in 1: backpressure from the Ethernet core.
- `grant` out `N_SRC`: one-hot owner; all zero when idle.
- `pkt_cnt` out `N_SRC*CNT_W`: packets completed per source.
- `err_keep` out 1: sticky flag; set when a non-LAST beat is accepted with KEEP ≠ 8'hff.

## Operation
- FSM has two states, IDLE and BUSY.
- IDLE behaviour:
  - `src_READY` is all zero.
  - If any `src_VALID` is high, select the first requesting index strictly after `last_grant`, searching cyclically.
  - Register the selection into `grant` and `last_grant`, then move to BUSY.
- BUSY behaviour:
  - `src_READY[g] = slice_in_ready`; all other `src_READY` bits are 0.
  - Forward source g's DATA/KEEP/LAST into the skid slice when `src_VALID[g] && slice_in_ready`.
  - When a LAST beat is accepted: increment `pkt_cnt[g]`, clear `grant`, return to IDLE.
- Every packet costs one arbitration bubble cycle. Sources deasserting VALID mid-packet simply stall the FSM in BUSY.
- `pkt_cnt` wraps modulo 2^CNT_W without saturation.
- `err_keep` is cleared only by reset. Beats that trigger it are still forwarded unchanged.
- The arbiter never inspects or modifies payload; header generation belongs to the sources.
- Skid slice:
  - Holds two entries, main and skid.
  - `slice_in_ready` is registered and equals "skid entry empty".
  - The output always comes from the main entry.

## Timing
- Reset values:
  - `stream_out_VALID`=0, `stream_out_DATA`=0, `stream_out_KEEP`=0, `stream_out_LAST`=0.
  - `src_READY`=0, `grant`=0, `pkt_cnt`=0, `err_keep`=0.
  - Slice is empty with `slice_in_ready`=1.
  - `last_grant`=`N_SRC`-1, so the first grant after reset goes to source 0 if it is requesting.
- Latency from idle:
  - VALID is seen in cycle 0 and the grant is registered at the end of cycle 0.
  - The first beat is accepted in cycle 1.
  - `stream_out_VALID` is high in cycle 2.
- Throughput: one beat per cycle while `stream_out_READY`=1.
- On `stream_out_READY` deassertion, the slice absorbs at most one extra beat. `slice_in_ready` falls the following cycle, and no beat is lost or duplicated.
- Simultaneous LAST accept and new requests: the FSM returns to IDLE and re-arbitrates next cycle, using the just-finished source as `last_grant`.
- Reset mid-packet: all state clears immediately and any partial packet is discarded. Downstream recovery is the core's responsibility.
- A single-beat packet (LAST on the first beat) is legal and behaves identically.

## Structure
- Package `eth_pkg` holds:
  - `localparam` `AXIS_DATA_W`=64 and `AXIS_KEEP_W`=8.
  - `typedef enum logic {ARB_IDLE, ARB_BUSY}`.
  - `typedef struct packed` `axis_beat_t` containing data, keep and last.
- Sub-module `axis_skid_slice` implements the two-entry register slice on `axis_beat_t`. It is reusable on the receive path.
- The round-robin selector is a function in the arbiter, not a separate module.

## Test plan
- Reset, then source 0 sends a 2-beat packet: beat 1 is 64'h0100000100030000 with KEEP ff; beat 2 is 64'h5073930200000000 with KEEP 0f and LAST. Required response: beats appear on `stream_out` in cycles 2–3 unchanged, `pkt_cnt[0]`=1, and `grant` returns to 0.
- All 4 sources continuously request 3-beat packets. Required response: grant order 0,1,2,3,0; packets are never interleaved; one bubble occurs between packets.
- `stream_out_READY` toggles 1,0,0,1 during an 8-beat packet. Required response: all 8 beats arrive in order and no `src_READY` is high while the skid entry is full.
- Source 2 sends a non-LAST beat with KEEP 8'h0f. Required response: `err_keep`=1 on the next cycle and the beat is still forwarded.
- `aresetn` is asserted mid-packet on beat 3 of 5. Required response: outputs reach reset values asynchronously; after release, the next grant goes to the lowest requesting source.
- Run 65536+1 single-beat packets from source 1 with `CNT_W`=16. Required response: `pkt_cnt[1]` wraps to 1.
